// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
// Shares the single register-file write port between the pipeline write-back
// stage (pipe) and a slow auxiliary requester (aux). Pipe normally wins, but
// an aux request that has waited MAX_WAIT-1 cycles forces a grant: the
// colliding pipe write is parked in a one-entry hold buffer, the pipeline is
// frozen for one cycle, and the parked write is drained on the next cycle.
module wb_port_arbiter #(
    parameter int WORD_WIDTH = 32,
    parameter int DST_WIDTH  = 4,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  pipe_wb_en_i,
    input  logic [DST_WIDTH-1:0]  pipe_dst_i,
    input  logic [WORD_WIDTH-1:0] pipe_value_i,
    input  logic                  aux_valid_i,
    input  logic [DST_WIDTH-1:0]  aux_dst_i,
    input  logic [WORD_WIDTH-1:0] aux_value_i,
    output logic                  aux_ready_o,
    output logic                  pipe_freeze_o,
    output logic                  rf_wb_en_o,
    output logic [DST_WIDTH-1:0]  rf_dst_o,
    output logic [WORD_WIDTH-1:0] rf_value_o
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT - 1);

    typedef enum logic {
        NORMAL = 1'b0,
        DRAIN  = 1'b1
    } state_t;

    state_t                  state_q,       state_d;
    logic                    hold_valid_q,  hold_valid_d;
    logic [DST_WIDTH-1:0]    hold_dst_q,    hold_dst_d;
    logic [WORD_WIDTH-1:0]   hold_value_q,  hold_value_d;
    logic [CNT_W-1:0]        wait_cnt_q,    wait_cnt_d;
    logic                    pipe_freeze_q, pipe_freeze_d;
    logic                    rf_wb_en_q,    rf_wb_en_d;
    logic [DST_WIDTH-1:0]    rf_dst_q,      rf_dst_d;
    logic [WORD_WIDTH-1:0]   rf_value_q,    rf_value_d;

    logic force_grant;
    logic aux_ready;

    // Grant decision: aux wins when pipe is idle or when its wait has run out.
    always_comb begin
        force_grant = (state_q == NORMAL) && aux_valid_i && pipe_wb_en_i
                      && (wait_cnt_q == CNT_MAX);
        aux_ready   = rst_ni && (state_q == NORMAL) && aux_valid_i
                      && (!pipe_wb_en_i || force_grant);
    end

    // Next-state logic for the FSM, hold buffer, wait counter and write port.
    always_comb begin
        state_d       = state_q;
        hold_valid_d  = hold_valid_q;
        hold_dst_d    = hold_dst_q;
        hold_value_d  = hold_value_q;
        pipe_freeze_d = 1'b0;
        rf_wb_en_d    = 1'b0;
        rf_dst_d      = rf_dst_q;
        rf_value_d    = rf_value_q;

        case (state_q)
            NORMAL: begin
                if (force_grant) begin
                    rf_wb_en_d    = 1'b1;
                    rf_dst_d      = aux_dst_i;
                    rf_value_d    = aux_value_i;
                    hold_valid_d  = 1'b1;
                    hold_dst_d    = pipe_dst_i;
                    hold_value_d  = pipe_value_i;
                    pipe_freeze_d = 1'b1;
                    state_d       = DRAIN;
                end else if (pipe_wb_en_i) begin
                    rf_wb_en_d = 1'b1;
                    rf_dst_d   = pipe_dst_i;
                    rf_value_d = pipe_value_i;
                end else if (aux_valid_i) begin
                    rf_wb_en_d = 1'b1;
                    rf_dst_d   = aux_dst_i;
                    rf_value_d = aux_value_i;
                end
            end
            DRAIN: begin
                rf_wb_en_d   = hold_valid_q;
                rf_dst_d     = hold_dst_q;
                rf_value_d   = hold_value_q;
                hold_valid_d = 1'b0;
                state_d      = NORMAL;
            end
            default: begin
                state_d = NORMAL;
            end
        endcase

        if (aux_valid_i && !aux_ready) begin
            wait_cnt_d = (wait_cnt_q == CNT_MAX) ? wait_cnt_q : wait_cnt_q + CNT_W'(1);
        end else begin
            wait_cnt_d = '0;
        end
    end

    // State register; reset discards any parked write along with the pipeline.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= NORMAL;
            hold_valid_q  <= 1'b0;
            hold_dst_q    <= '0;
            hold_value_q  <= '0;
            wait_cnt_q    <= '0;
            pipe_freeze_q <= 1'b0;
            rf_wb_en_q    <= 1'b0;
            rf_dst_q      <= '0;
            rf_value_q    <= '0;
        end else begin
            state_q       <= state_d;
            hold_valid_q  <= hold_valid_d;
            hold_dst_q    <= hold_dst_d;
            hold_value_q  <= hold_value_d;
            wait_cnt_q    <= wait_cnt_d;
            pipe_freeze_q <= pipe_freeze_d;
            rf_wb_en_q    <= rf_wb_en_d;
            rf_dst_q      <= rf_dst_d;
            rf_value_q    <= rf_value_d;
        end
    end

    assign aux_ready_o   = aux_ready;
    assign pipe_freeze_o = pipe_freeze_q;
    assign rf_wb_en_o    = rf_wb_en_q;
    assign rf_dst_o      = rf_dst_q;
    assign rf_value_o    = rf_value_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter
// Directed bench for wb_port_arbiter with MAX_WAIT=4: reset, single
// requesters, starvation-forced grant with hold-buffer drain, same-destination
// ordering, and asynchronous reset while a parked write is pending.
module tb_wb_port_arbiter;

    logic        clk;
    logic        rstN;
    logic        pipeWbEn;
    logic [3:0]  pipeDst;
    logic [31:0] pipeValue;
    logic        auxValid;
    logic [3:0]  auxDst;
    logic [31:0] auxValue;
    logic        auxReady;
    logic        pipeFreeze;
    logic        rfWbEn;
    logic [3:0]  rfDst;
    logic [31:0] rfValue;

    int total = 0;
    int bad   = 0;

    wb_port_arbiter #(
        .WORD_WIDTH(32),
        .DST_WIDTH (4),
        .MAX_WAIT  (4)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rstN),
        .pipe_wb_en_i (pipeWbEn),
        .pipe_dst_i   (pipeDst),
        .pipe_value_i (pipeValue),
        .aux_valid_i  (auxValid),
        .aux_dst_i    (auxDst),
        .aux_value_i  (auxValue),
        .aux_ready_o  (auxReady),
        .pipe_freeze_o(pipeFreeze),
        .rf_wb_en_o   (rfWbEn),
        .rf_dst_o     (rfDst),
        .rf_value_o   (rfValue)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drive all request inputs at once.
    task automatic applyStimulus(input logic pEn, input logic [3:0] pDst, input logic [31:0] pVal,
                                 input logic aVal, input logic [3:0] aDst, input logic [31:0] aValue);
        pipeWbEn  = pEn;
        pipeDst   = pDst;
        pipeValue = pVal;
        auxValid  = aVal;
        auxDst    = aDst;
        auxValue  = aValue;
        #1;
    endtask

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Check the whole registered write port in one go.
    task automatic checkWrite(input string tag, input logic en, input logic [3:0] dst,
                              input logic [31:0] val, input logic frz);
        checkOutput({tag, ".en"},     {31'd0, rfWbEn},     {31'd0, en});
        if (en) begin
            checkOutput({tag, ".dst"},   {28'd0, rfDst},  {28'd0, dst});
            checkOutput({tag, ".value"}, rfValue,          val);
        end
        checkOutput({tag, ".freeze"}, {31'd0, pipeFreeze}, {31'd0, frz});
    endtask

    // Advance to just after the next rising edge.
    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Directed sequence.
    initial begin
        rstN = 1'b0;
        applyStimulus(1'b1, 4'd3, 32'hFFFF_FFFF, 1'b1, 4'd5, 32'h5555_5555);

        // Reset with every input active.
        stepCycle();
        stepCycle();
        checkWrite("reset", 1'b0, 4'd0, 32'd0, 1'b0);
        checkOutput("reset.dst",   {28'd0, rfDst}, 32'd0);
        checkOutput("reset.value", rfValue, 32'd0);
        checkOutput("reset.ready_both", {31'd0, auxReady}, 32'd0);
        applyStimulus(1'b0, 4'd3, 32'd0, 1'b1, 4'd5, 32'h5555_5555);
        checkOutput("reset.ready_aux_only", {31'd0, auxReady}, 32'd0);
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        rstN = 1'b1;
        stepCycle();
        checkWrite("idle", 1'b0, 4'd0, 32'd0, 1'b0);

        // Pipe only.
        applyStimulus(1'b1, 4'd3, 32'h0000_00AA, 1'b0, 4'd0, 32'd0);
        checkOutput("pipe.ready", {31'd0, auxReady}, 32'd0);
        stepCycle();
        checkWrite("pipe", 1'b1, 4'd3, 32'h0000_00AA, 1'b0);

        // Aux only.
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b1, 4'd5, 32'h0000_1234);
        checkOutput("aux.ready", {31'd0, auxReady}, 32'd1);
        stepCycle();
        checkWrite("aux", 1'b1, 4'd5, 32'h0000_1234, 1'b0);
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        stepCycle();
        checkWrite("aux.idle", 1'b0, 4'd0, 32'd0, 1'b0);

        // Starvation: pipe wins three cycles, fourth forces aux.
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1'b1, 4'(i), 32'h100 + 32'(i), 1'b1, 4'd7, 32'h77);
            checkOutput("starve.ready_low", {31'd0, auxReady}, 32'd0);
            stepCycle();
            checkWrite("starve.pipe", 1'b1, 4'(i), 32'h100 + 32'(i), 1'b0);
        end
        applyStimulus(1'b1, 4'd4, 32'h104, 1'b1, 4'd7, 32'h77);
        checkOutput("starve.force_ready", {31'd0, auxReady}, 32'd1);
        stepCycle();
        checkWrite("starve.aux", 1'b1, 4'd7, 32'h77, 1'b1);
        // During drain pipe is ignored and a new aux request is not granted.
        applyStimulus(1'b1, 4'd9, 32'hDEAD, 1'b1, 4'd8, 32'h88);
        checkOutput("drain.ready", {31'd0, auxReady}, 32'd0);
        stepCycle();
        checkWrite("drain.held", 1'b1, 4'd4, 32'h104, 1'b0);
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b1, 4'd8, 32'h88);
        checkOutput("after.ready", {31'd0, auxReady}, 32'd1);
        stepCycle();
        checkWrite("after.aux", 1'b1, 4'd8, 32'h88, 1'b0);

        // Same destination on a forced grant: aux value then pipe value.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 4'(10 + i), 32'hA0 + 32'(i), 1'b1, 4'd2, 32'h11);
            stepCycle();
            checkWrite("same.pipe", 1'b1, 4'(10 + i), 32'hA0 + 32'(i), 1'b0);
        end
        applyStimulus(1'b1, 4'd2, 32'h22, 1'b1, 4'd2, 32'h11);
        checkOutput("same.force_ready", {31'd0, auxReady}, 32'd1);
        stepCycle();
        checkWrite("same.aux", 1'b1, 4'd2, 32'h11, 1'b1);
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        stepCycle();
        checkWrite("same.held", 1'b1, 4'd2, 32'h22, 1'b0);
        stepCycle();
        checkWrite("same.idle", 1'b0, 4'd0, 32'd0, 1'b0);

        // Asynchronous reset while a parked write is pending.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 4'(12 + i), 32'hC0 + 32'(i), 1'b1, 4'd6, 32'h66);
            stepCycle();
        end
        applyStimulus(1'b1, 4'd14, 32'hEE, 1'b1, 4'd6, 32'h66);
        stepCycle();
        checkWrite("rst.aux", 1'b1, 4'd6, 32'h66, 1'b1);
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        #1;
        rstN = 1'b0;
        #1;
        checkWrite("rst.async", 1'b0, 4'd0, 32'd0, 1'b0);
        checkOutput("rst.async_dst", {28'd0, rfDst}, 32'd0);
        #3;
        rstN = 1'b1;
        stepCycle();
        checkWrite("rst.lost", 1'b0, 4'd0, 32'd0, 1'b0);
        applyStimulus(1'b1, 4'd15, 32'hF0, 1'b0, 4'd0, 32'd0);
        stepCycle();
        checkWrite("rst.resume", 1'b1, 4'd15, 32'hF0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
